// File: rtl/set_assoc_cache_lru_if.sv
`default_nettype none
// ============================================================================
//  set_assoc_cache_lru_if
//  CPU load/store port and memory port of the set-associative cache.
//  Optional macro CACHE_STATS_EN adds the hit/miss/write-back counters.
//  Revision: 1.0
// ============================================================================
interface set_assoc_cache_lru_if;
  logic        cpu_op;
  logic        cpu_valid;
  logic [31:0] cache_addr;
  logic [31:0] cpu_write_data;
  logic        cache_ready;
  logic [31:0] cache_data;
  logic        cache_op;
  logic        cache_valid;
  logic [31:0] mem_addr;
  logic [31:0] cache_write_data;
  logic        mem_ready;
  logic [31:0] mem_data;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [31:0] wb_count;
`endif

  modport slave (
    input  cpu_op, cpu_valid, cache_addr, cpu_write_data, mem_ready, mem_data,
    output cache_ready, cache_data, cache_op, cache_valid, mem_addr, cache_write_data
`ifdef CACHE_STATS_EN
    , output hit_count, miss_count, wb_count
`endif
  );

  modport master (
    output cpu_op, cpu_valid, cache_addr, cpu_write_data, mem_ready, mem_data,
    input  cache_ready, cache_data, cache_op, cache_valid, mem_addr, cache_write_data
`ifdef CACHE_STATS_EN
    , input hit_count, miss_count, wb_count
`endif
  );
endinterface
`default_nettype wire

// File: rtl/set_assoc_cache_lru.sv
`default_nettype none
// ============================================================================
//  set_assoc_cache_lru
//  N-way write-back/write-allocate cache, one word per line, true-LRU per set.
//  Optional macro CACHE_STATS_EN adds saturating hit/miss/write-back counters.
//  Revision: 1.0
// ============================================================================
module set_assoc_cache_lru #(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 8
) (
  input wire logic             clk,
  input wire logic             nrst,
  set_assoc_cache_lru_if.slave bus
);
  localparam int SETS  = 2 ** SET_BITS;
  localparam int TAG_W = 30 - SET_BITS;
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    REFILL     = 2'd2
  } state_t;

  state_t              r_state;
  logic [WAYS-1:0]     r_valid [SETS];
  logic [WAYS-1:0]     r_dirty [SETS];
  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
  logic [31:0]         r_data  [SETS][WAYS];
  logic [AGE_W-1:0]    r_age   [SETS][WAYS];
  logic [AGE_W-1:0]    r_victim;
  logic [SET_BITS-1:0] r_set;
  logic [TAG_W-1:0]    r_miss_tag;
  logic                r_mem_valid;
  logic                r_mem_op;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_wdata;
  logic                r_retry;

  logic [SET_BITS-1:0] w_set;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic [AGE_W-1:0]    w_hit_way;
  logic [AGE_W-1:0]    w_victim;
  logic                w_ready;
  logic                w_lru_en;
  logic [SET_BITS-1:0] w_lru_set;
  logic [AGE_W-1:0]    w_lru_way;
  logic [1:0]          w_unused_addr_bits;

  assign w_set              = bus.cache_addr[SET_BITS+1:2];
  assign w_tag              = bus.cache_addr[31:SET_BITS+2];
  assign w_unused_addr_bits = bus.cache_addr[1:0];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
    end
  end

  // Oldest way by default; the downward scan lets the lowest invalid way win.
  always_comb begin
    w_victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_age[w_set][w] == AGE_W'(WAYS - 1)) w_victim = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_set][w]) w_victim = AGE_W'(w);
    end
  end

  assign w_ready = (r_state == IDLE) && bus.cpu_valid && w_hit;

  always_comb begin
    w_lru_en  = 1'b0;
    w_lru_set = w_set;
    w_lru_way = w_hit_way;
    if (w_ready) begin
      w_lru_en = 1'b1;
    end else if ((r_state == REFILL) && bus.mem_ready) begin
      w_lru_en  = 1'b1;
      w_lru_set = r_set;
      w_lru_way = r_victim;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_victim    <= '0;
      r_set       <= '0;
      r_miss_tag  <= '0;
      r_mem_valid <= 1'b0;
      r_mem_op    <= 1'b1;
      r_mem_addr  <= '0;
      r_wdata     <= '0;
      r_retry     <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w]  <= '0;
          r_data[s][w] <= '0;
          r_age[s][w]  <= AGE_W'(w);
        end
      end
    end else begin
      if (w_lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == w_lru_way)
            r_age[w_lru_set][w] <= '0;
          else if (r_age[w_lru_set][w] < r_age[w_lru_set][w_lru_way])
            r_age[w_lru_set][w] <= r_age[w_lru_set][w] + 1'b1;
        end
      end
      case (r_state)
        IDLE: begin
          if (!bus.cpu_valid) begin
            r_retry <= 1'b0;
          end else if (w_hit) begin
            r_retry <= 1'b0;
            if (!bus.cpu_op) begin
              r_data[w_set][w_hit_way]  <= bus.cpu_write_data;
              r_dirty[w_set][w_hit_way] <= 1'b1;
            end
          end else begin
            r_victim    <= w_victim;
            r_set       <= w_set;
            r_miss_tag  <= w_tag;
            r_mem_valid <= 1'b1;
            if (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim]) begin
              r_state    <= WRITE_BACK;
              r_mem_op   <= 1'b0;
              r_mem_addr <= {r_tag[w_set][w_victim], w_set, 2'b00};
              r_wdata    <= r_data[w_set][w_victim];
            end else begin
              r_state    <= REFILL;
              r_mem_op   <= 1'b1;
              r_mem_addr <= {bus.cache_addr[31:2], 2'b00};
            end
          end
        end
        WRITE_BACK: begin
          if (bus.mem_ready) begin
            r_dirty[r_set][r_victim] <= 1'b0;
            r_valid[r_set][r_victim] <= 1'b0;
            r_state    <= REFILL;
            r_mem_op   <= 1'b1;
            r_mem_addr <= {r_miss_tag, r_set, 2'b00};
            r_wdata    <= '0;
          end
        end
        REFILL: begin
          // The request re-evaluates as a hit next cycle; r_retry marks it.
          if (bus.mem_ready) begin
            r_data[r_set][r_victim]  <= bus.mem_data;
            r_tag[r_set][r_victim]   <= r_miss_tag;
            r_valid[r_set][r_victim] <= 1'b1;
            r_dirty[r_set][r_victim] <= 1'b0;
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_retry     <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cache_ready      = w_ready;
  assign bus.cache_data       = (w_ready && bus.cpu_op) ? r_data[w_set][w_hit_way] : '0;
  assign bus.cache_valid      = r_mem_valid;
  assign bus.cache_op         = r_mem_op;
  assign bus.mem_addr         = r_mem_addr;
  assign bus.cache_write_data = r_wdata;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic [31:0] r_wb_count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_wb_count   <= '0;
    end else begin
      if (w_ready && !r_retry && (r_hit_count != '1))
        r_hit_count <= r_hit_count + 1'b1;
      if ((r_state == IDLE) && bus.cpu_valid && !w_hit && (r_miss_count != '1))
        r_miss_count <= r_miss_count + 1'b1;
      if ((r_state == WRITE_BACK) && bus.mem_ready && (r_wb_count != '1))
        r_wb_count <= r_wb_count + 1'b1;
    end
  end

  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;
  assign bus.wb_count   = r_wb_count;
`else
  logic w_unused_retry;
  assign w_unused_retry = r_retry;
`endif
endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache_lru.sv
`default_nettype none
// ============================================================================
//  tb_set_assoc_cache_lru
//  Directed scenarios against a timestamp-LRU reference model of the cache.
//  Revision: 1.0
// ============================================================================
module tb_set_assoc_cache_lru;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  set_assoc_cache_lru_if bus ();
  set_assoc_cache_lru #(.WAYS(4), .SET_BITS(8)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- backing memory and responder ----------------
  logic [31:0] bmem [logic [31:0]];
  int mem_lat = 0;
  int wait_cnt = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  always begin
    @(posedge clk); #1;
    if (!nrst) begin
      bus.mem_ready = 1'b0; bus.mem_data = '0; wait_cnt = 0;
    end else if (bus.mem_ready) begin
      bus.mem_ready = 1'b0; bus.mem_data = '0; wait_cnt = 0;
    end else if (bus.cache_valid) begin
      if (wait_cnt >= mem_lat) begin
        bus.mem_ready = 1'b1;
        if (bus.cache_op) bus.mem_data = mem_rd(bus.mem_addr);
        else bmem[bus.mem_addr] = bus.cache_write_data;
      end else begin
        wait_cnt++;
      end
    end
  end

  // ---------------- reference model: recency by timestamp ----------------
  bit          mv    [256][4];
  bit          md    [256][4];
  logic [21:0] mt    [256][4];
  logic [31:0] mdat  [256][4];
  longint      mstamp[256][4];
  longint      mtime;
  int          m_mode;          // 0 idle, 1 write-back, 2 refill
  int          m_vic;
  logic [7:0]  m_set;
  logic [21:0] m_tag;
  logic [31:0] m_raddr;
`ifdef CACHE_STATS_EN
  int m_hits, m_miss, m_wb;
  bit m_retry;
`endif

  function automatic int m_lookup(input logic [31:0] a);
    for (int w = 0; w < 4; w++)
      if (mv[a[9:2]][w] && mt[a[9:2]][w] == a[31:10]) return w;
    return -1;
  endfunction

  function automatic int m_pick(input logic [7:0] s);
    int v = 0;
    for (int w = 3; w >= 0; w--) if (!mv[s][w]) return w;
    for (int w = 1; w < 4; w++) if (mstamp[s][w] < mstamp[s][v]) v = w;
    return v;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < 256; s++)
        for (int w = 0; w < 4; w++) begin
          mv[s][w] <= 0; md[s][w] <= 0; mt[s][w] <= '0; mdat[s][w] <= '0;
          mstamp[s][w] <= -longint'(w);
        end
      mtime <= 1; m_mode <= 0; m_vic <= 0; m_set <= '0; m_tag <= '0; m_raddr <= '0;
`ifdef CACHE_STATS_EN
      m_hits <= 0; m_miss <= 0; m_wb <= 0; m_retry <= 0;
`endif
    end else begin
      case (m_mode)
        0: if (bus.cpu_valid) begin
          if (m_lookup(bus.cache_addr) >= 0) begin
            mstamp[bus.cache_addr[9:2]][m_lookup(bus.cache_addr)] <= mtime;
            mtime <= mtime + 1;
            if (!bus.cpu_op) begin
              mdat[bus.cache_addr[9:2]][m_lookup(bus.cache_addr)] <= bus.cpu_write_data;
              md[bus.cache_addr[9:2]][m_lookup(bus.cache_addr)] <= 1;
            end
`ifdef CACHE_STATS_EN
            if (!m_retry) m_hits <= m_hits + 1;
            m_retry <= 0;
`endif
          end else begin
            m_vic   <= m_pick(bus.cache_addr[9:2]);
            m_set   <= bus.cache_addr[9:2];
            m_tag   <= bus.cache_addr[31:10];
            m_raddr <= {bus.cache_addr[31:2], 2'b00};
            m_mode  <= (mv[bus.cache_addr[9:2]][m_pick(bus.cache_addr[9:2])] &&
                        md[bus.cache_addr[9:2]][m_pick(bus.cache_addr[9:2])]) ? 1 : 2;
`ifdef CACHE_STATS_EN
            m_miss <= m_miss + 1;
`endif
          end
        end else begin
`ifdef CACHE_STATS_EN
          m_retry <= 0;
`endif
        end
        1: if (bus.mem_ready) begin
          md[m_set][m_vic] <= 0; mv[m_set][m_vic] <= 0; m_mode <= 2;
`ifdef CACHE_STATS_EN
          m_wb <= m_wb + 1;
`endif
        end
        default: if (bus.mem_ready) begin
          mdat[m_set][m_vic] <= bus.mem_data; mt[m_set][m_vic] <= m_tag;
          mv[m_set][m_vic] <= 1; md[m_set][m_vic] <= 0;
          mstamp[m_set][m_vic] <= mtime; mtime <= mtime + 1; m_mode <= 0;
`ifdef CACHE_STATS_EN
          m_retry <= 1;
`endif
        end
      endcase
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (nrst) begin
      automatic int w = -1;
      automatic logic e_ready = 1'b0;
      automatic logic [31:0] e_data = '0;
      if (m_mode == 0 && bus.cpu_valid) w = m_lookup(bus.cache_addr);
      if (w >= 0) begin
        e_ready = 1'b1;
        if (bus.cpu_op) e_data = mdat[bus.cache_addr[9:2]][w];
      end
      chk("cache_ready", bus.cache_ready, e_ready);
      chk("cache_data", bus.cache_data, e_data);
      chk("cache_valid", bus.cache_valid, m_mode != 0);
      if (m_mode != 0) begin
        chk("cache_op", bus.cache_op, m_mode == 2);
        chk("mem_addr", bus.mem_addr, (m_mode == 1) ? {mt[m_set][m_vic], m_set, 2'b00} : m_raddr);
        if (m_mode == 1) chk("cache_write_data", bus.cache_write_data, mdat[m_set][m_vic]);
      end
    end
  end

  // ---------------- CPU request driver ----------------
  logic [31:0] rd, wb_addr, wb_data, rf_addr;
  int cyc;
  bit saw_valid, saw_wb;

  task automatic req(input bit op, input logic [31:0] a, input logic [31:0] wd);
    bit got = 0;
    bus.cpu_valid = 1'b1; bus.cpu_op = op; bus.cache_addr = a; bus.cpu_write_data = wd;
    cyc = 0; rd = '0; saw_valid = 0; saw_wb = 0; wb_addr = '0; wb_data = '0; rf_addr = '0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.cache_valid) saw_valid = 1;
      if (bus.cache_valid && !bus.cache_op && !saw_wb) begin
        saw_wb = 1; wb_addr = bus.mem_addr; wb_data = bus.cache_write_data;
      end
      if (bus.cache_valid && bus.cache_op) rf_addr = bus.mem_addr;
      if (bus.cache_ready) begin got = 1; rd = bus.cache_data; end
    end
    if (!got) chk("request timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.cpu_valid = 1'b0;
  endtask

  initial begin
    bus.cpu_valid = 0; bus.cpu_op = 1; bus.cache_addr = '0; bus.cpu_write_data = '0;
    bus.mem_ready = 0; bus.mem_data = '0;
    bmem[32'h0000_1004] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk); #1;
    chk("rst cache_ready", bus.cache_ready, 0);
    chk("rst cache_data", bus.cache_data, 0);
    chk("rst cache_valid", bus.cache_valid, 0);
    chk("rst cache_op", bus.cache_op, 1);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst cache_write_data", bus.cache_write_data, 0);
    nrst = 1'b1;

    // cold read miss
    req(1, 32'h0000_1004, 0);
    chk("cold data", rd, 32'hDEAD_BEEF);
    chk("cold latency", cyc, 3);
    chk("cold no wb", saw_wb, 0);
    chk("cold refill addr", rf_addr, 32'h0000_1004);

    // write hit then read
    req(0, 32'h0000_1004, 32'h1234_5678);
    chk("write hit latency", cyc, 1);
    chk("write hit no mem", saw_valid, 0);
    req(1, 32'h0000_1004, 0);
    chk("read after write", rd, 32'h1234_5678);
    chk("read hit latency", cyc, 1);

    // LRU victim in set 2
    req(1, 32'h0000_0008, 0);
    chk("fill latency", cyc, 3);
    req(1, 32'h0000_0408, 0);
    req(1, 32'h0000_0808, 0);
    req(1, 32'h0000_0C08, 0);
    req(1, 32'h0000_0008, 0);
    chk("lru touch hit", cyc, 1);
    req(1, 32'h0000_1008, 0);
    chk("lru replace miss", cyc, 3);
    chk("lru replace clean", saw_wb, 0);
    req(1, 32'h0000_0008, 0);
    chk("mru survives", cyc, 1);
    req(1, 32'h0000_0408, 0);
    chk("lru evicted", cyc, 3);
    chk("lru refetch data", rd, 32'h5A5A_0408);

    // dirty eviction
    req(0, 32'h0000_0C08, 32'hA5A5_A5A5);
    chk("dirty write hit", cyc, 1);
    req(1, 32'h0000_0008, 0);
    req(1, 32'h0000_1008, 0);
    req(1, 32'h0000_0408, 0);
    chk("age hits", cyc, 1);
    mem_lat = 2;
    req(1, 32'h0000_1408, 0);
    chk("wb seen", saw_wb, 1);
    chk("wb addr", wb_addr, 32'h0000_0C08);
    chk("wb data", wb_data, 32'hA5A5_A5A5);
    chk("wb refill addr", rf_addr, 32'h0000_1408);
    chk("wb latency", cyc, 9);
    mem_lat = 0;
    req(1, 32'h0000_0C08, 0);
    chk("written-back data", rd, 32'hA5A5_A5A5);
    chk("written-back clean evict", saw_wb, 0);

    // stalled memory
    mem_lat = 5;
    req(1, 32'h0000_2010, 0);
    chk("stall latency", cyc, 8);
    chk("stall data", rd, 32'h5A5A_2010);

    // request abandoned mid-refill still installs the line
    mem_lat = 3;
    bus.cpu_valid = 1; bus.cpu_op = 1; bus.cache_addr = 32'h0000_3010;
    repeat (3) @(posedge clk); #1;
    bus.cpu_valid = 0;
    repeat (10) @(posedge clk); #1;
    mem_lat = 0;
    req(1, 32'h0000_3010, 0);
    chk("abandoned line hit", cyc, 1);
    chk("abandoned line data", rd, 32'h5A5A_3010);

    // reset in REFILL
    mem_lat = 20;
    bus.cpu_valid = 1; bus.cpu_op = 1; bus.cache_addr = 32'h0000_4010;
    repeat (4) @(posedge clk); #1;
    chk("pre-reset valid", bus.cache_valid, 1);
    #2 nrst = 1'b0;
    #1;
    chk("async reset valid", bus.cache_valid, 0);
    chk("async reset addr", bus.mem_addr, 0);
    bus.cpu_valid = 0;
    @(posedge clk); #1;
    nrst = 1'b1;
    mem_lat = 0;
    req(1, 32'h0000_1004, 0);
    chk("post-reset miss", cyc, 3);
    chk("dirty data lost", rd, 32'hDEAD_BEEF);
    req(1, 32'h0000_2010, 0);
    chk("post-reset miss 2", cyc, 3);

`ifdef CACHE_STATS_EN
    repeat (2) @(posedge clk); #1;
    chk("hit_count", bus.hit_count, m_hits);
    chk("miss_count", bus.miss_count, m_miss);
    chk("wb_count", bus.wb_count, m_wb);
`endif
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
